fetch_stage: RTL and testbench

Instruction-fetch stage of the single-issue processor. Owns the PC, issues word reads to the synchronous instruction ROM, buffers returned instructions in a 2-entry skid buffer, and presents them with a valid/ready handshake to decode. Decode slices `opcode` and `func` straight into the control decoder. Branch/jump resolution redirects the PC through a one-cycle redirect port that flushes all fetched-but-unconsumed work.

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_buffer.sv | 69 ++++++
 rtl/fetch_stage.sv | 77 +++++++
 tb/tb_fetch_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared ISA field positions and opcode constants for the fetch stage and the
// control decoder.
package fetch_stage_pkg;

    localparam int INSN_W     = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;
    localparam int FUNC_MSB   = 6;
    localparam int FUNC_LSB   = 2;

    typedef enum logic [4:0] {
        OP_RTYPE = 5'b00000,
        OP_ADDI  = 5'b00101,
        OP_SW    = 5'b00111,
        OP_LW    = 5'b01000
    } opcode_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry skid FIFO of {instruction, fetch PC}; entry 0 is always the head.
module fetch_buffer
    import fetch_stage_pkg::*;
#(
    parameter int PC_W   = 12,
    parameter int INSN_W = fetch_stage_pkg::INSN_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [INSN_W-1:0] push_insn,
    input  logic [PC_W-1:0]   push_pc,
    input  logic              pop,
    input  logic              flush,
    output logic [INSN_W-1:0] head_insn,
    output logic [PC_W-1:0]   head_pc,
    output logic [1:0]        count
);

    logic [INSN_W-1:0] insn0, insn1;
    logic [PC_W-1:0]   pc0, pc1;

    // Flush only drops the occupancy; stale entry contents are hidden by count.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= 2'd0;
            insn0 <= '0;
            insn1 <= '0;
            pc0   <= '0;
            pc1   <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        insn0 <= push_insn;
                        pc0   <= push_pc;
                    end else begin
                        insn1 <= push_insn;
                        pc1   <= push_pc;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    insn0 <= insn1;
                    pc0   <= pc1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        insn0 <= insn1;
                        pc0   <= pc1;
                        insn1 <= push_insn;
                        pc1   <= push_pc;
                    end else begin
                        insn0 <= push_insn;
                        pc0   <= push_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_insn = insn0;
    assign head_pc   = pc0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues ROM reads, and hands buffered
// instructions to decode over a valid/ready handshake.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int PC_W   = 12,
    parameter int INSN_W = fetch_stage_pkg::INSN_W
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INSN_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              insn_valid,
    input  logic              insn_ready,
    output logic [INSN_W-1:0] insn,
    output logic [PC_W-1:0]   insn_pc,
    output logic [4:0]        opcode,
    output logic [4:0]        func
);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] req_pc;
    logic            inflight;
    logic [1:0]      count;
    logic            pop;
    logic            issue;
    logic [2:0]      occupancy;

    // A redirect cancels the pop so the head it would have consumed is simply discarded.
    assign insn_valid = (count != 2'd0);
    assign pop        = insn_valid & insn_ready & ~redirect;
    assign occupancy  = {1'b0, count} + {2'b00, inflight};
    assign issue      = reset_n & ~redirect & (occupancy < (3'd2 + {2'b00, pop}));

    assign imem_req  = issue;
    assign imem_addr = pc;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc       <= '0;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else if (redirect) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc     <= pc + 1'b1;
                req_pc <= pc;
            end
        end
    end

    fetch_buffer #(
        .PC_W   (PC_W),
        .INSN_W (INSN_W)
    ) u_buffer (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_insn (imem_rdata),
        .push_pc   (req_pc),
        .pop       (pop),
        .flush     (redirect),
        .head_insn (insn),
        .head_pc   (insn_pc),
        .count     (count)
    );

    assign opcode = insn[OPCODE_MSB:OPCODE_LSB];
    assign func   = insn[FUNC_MSB:FUNC_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall, redirect, wrap, decode
// fields and mid-stream reset against a behavioural ROM.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic        insn_valid;
    logic        insn_ready;
    logic [31:0] insn;
    logic [11:0] insn_pc;
    logic [4:0]  opcode;
    logic [4:0]  func;

    int errors = 0;
    int checks = 0;

    fetch_stage #(.PC_W(12), .INSN_W(32)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .insn_valid  (insn_valid),
        .insn_ready  (insn_ready),
        .insn        (insn),
        .insn_pc     (insn_pc),
        .opcode      (opcode),
        .func        (func)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] rom_word(input logic [11:0] addr);
        if (addr == 12'h100) return 32'h2842_0000;
        if (addr == 12'h101) return 32'h0000_0014;
        return 32'h1000_0000 + {20'd0, addr};
    endfunction

    // Synchronous ROM: data for the address presented in one cycle appears in the next.
    always @(posedge clock) imem_rdata <= rom_word(imem_addr);

    task automatic applyStimulus(input logic rst_n, input logic ready,
                                 input logic redir, input logic [11:0] rpc);
        @(posedge clock);
        #1;
        reset_n     = rst_n;
        insn_ready  = ready;
        redirect    = redir;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkInsn(input string tag, input logic [11:0] pc);
        checkOutput({tag, ".valid"}, {31'd0, insn_valid}, 32'd1);
        checkOutput({tag, ".pc"}, {20'd0, insn_pc}, {20'd0, pc});
        checkOutput({tag, ".insn"}, insn, rom_word(pc));
    endtask

    task automatic checkReq(input string tag, input logic req, input logic [11:0] addr);
        checkOutput({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
        if (req) checkOutput({tag, ".addr"}, {20'd0, imem_addr}, {20'd0, addr});
    endtask

    initial begin
        reset_n     = 1'b0;
        insn_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 12'h000;

        applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h000);
        checkOutput("rst.req", {31'd0, imem_req}, 32'd0);
        checkOutput("rst.valid", {31'd0, insn_valid}, 32'd0);
        checkOutput("rst.insn", insn, 32'd0);
        checkOutput("rst.pc", {20'd0, insn_pc}, 32'd0);

        // Stream from reset release; fetch latency is two cycles.
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        checkReq("c0", 1'b1, 12'h000);
        checkOutput("c0.valid", {31'd0, insn_valid}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        checkReq("c1", 1'b1, 12'h001);
        checkOutput("c1.valid", {31'd0, insn_valid}, 32'd0);
        for (int c = 2; c < 10; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
            checkInsn("stream", 12'(c - 2));
            checkReq("stream", 1'b1, 12'(c));
        end

        // Decode stalls for five cycles while presenting word 8.
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 12'h000);
            checkInsn("stall", 12'h008);
            checkReq("stall", 1'b0, 12'h000);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        checkInsn("resume", 12'h008);
        checkReq("resume", 1'b1, 12'h00A);
        for (int k = 9; k < 14; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
            checkInsn("resume", 12'(k));
        end

        // Fill the buffer, then redirect to 0x080.
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h000);
        checkInsn("fill", 12'h00E);
        applyStimulus(1'b1, 1'b0, 1'b1, 12'h080);
        checkReq("redir1.n", 1'b0, 12'h000);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        checkOutput("redir1.n1.valid", {31'd0, insn_valid}, 32'd0);
        checkReq("redir1.n1", 1'b1, 12'h080);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        checkOutput("redir1.n2.valid", {31'd0, insn_valid}, 32'd0);
        checkReq("redir1.n2", 1'b1, 12'h081);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        checkInsn("redir1.n3", 12'h080);
        checkReq("redir1.n3", 1'b1, 12'h082);

        // Redirect to 0x100 in a cycle that would otherwise pop 0x081.
        applyStimulus(1'b1, 1'b1, 1'b1, 12'h100);
        checkInsn("redir2.n", 12'h081);
        checkReq("redir2.n", 1'b0, 12'h000);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        checkOutput("redir2.n1.valid", {31'd0, insn_valid}, 32'd0);
        checkReq("redir2.n1", 1'b1, 12'h100);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        checkOutput("redir2.n2.valid", {31'd0, insn_valid}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        checkInsn("redir2.n3", 12'h100);
        checkOutput("addi.opcode", {27'd0, opcode}, {27'd0, OP_ADDI});
        checkOutput("addi.func", {27'd0, func}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        checkInsn("rtype", 12'h101);
        checkOutput("rtype.opcode", {27'd0, opcode}, {27'd0, OP_RTYPE});
        checkOutput("rtype.func", {27'd0, func}, 32'd5);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        checkInsn("redir2.n5", 12'h102);

        // PC wrap from 0xFFF to 0x000.
        applyStimulus(1'b1, 1'b1, 1'b1, 12'hFFE);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        checkReq("wrap.n1", 1'b1, 12'hFFE);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        checkReq("wrap.n2", 1'b1, 12'hFFF);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        checkReq("wrap.n3", 1'b1, 12'h000);
        checkInsn("wrap.n3", 12'hFFE);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        checkInsn("wrap.n4", 12'hFFF);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        checkInsn("wrap.n5", 12'h000);

        // One-cycle reset mid-stream.
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h000);
        checkReq("mrst.n", 1'b0, 12'h000);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        checkOutput("mrst.valid", {31'd0, insn_valid}, 32'd0);
        checkOutput("mrst.insn", insn, 32'd0);
        checkOutput("mrst.pc", {20'd0, insn_pc}, 32'd0);
        checkOutput("mrst.opcode", {27'd0, opcode}, 32'd0);
        checkOutput("mrst.func", {27'd0, func}, 32'd0);
        checkReq("mrst.n1", 1'b1, 12'h000);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        checkOutput("mrst.n2.valid", {31'd0, insn_valid}, 32'd0);
        checkReq("mrst.n2", 1'b1, 12'h001);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        checkInsn("mrst.n3", 12'h000);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        checkInsn("mrst.n4", 12'h001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
